// File: rtl/step_counter.sv
// step_counter: up/down step counter with wrap or saturate boundary, sticky ovf/unf, tc pulse; snapshot enabled by STEP_COUNTER_SNAPSHOT_EN
module step_counter #(
    parameter int unsigned WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}},
    parameter bit SAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             snap_req,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic [WIDTH-1:0] snap
);
    logic [WIDTH:0] lim, lim1, ext, stp, sum;
    logic [WIDTH-1:0] nxt;
    logic up_bnd, dn_bnd, bnd, unused_msb;
    assign lim  = {1'b0, LIMIT};
    assign lim1 = lim + (WIDTH+1)'(1);
    assign ext  = {1'b0, count};
    assign stp  = {1'b0, step};
    assign sum  = ext + stp;
    // next count for an enabled step, worked at WIDTH+1 bits so nothing is truncated before the boundary test
    always_comb begin
        up_bnd = sum > lim;
        dn_bnd = count < step;
        bnd    = up_dn ? up_bnd : dn_bnd;
        {unused_msb, nxt} = up_dn ? (up_bnd ? (SAT ? lim : sum - lim1) : sum)
                                  : (dn_bnd ? (SAT ? '0 : ext + lim1 - stp) : ext - stp);
    end
    // count, terminal pulse and sticky flags with rst > clr > ld > en priority
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (ld) begin
            count <= (ld_val > LIMIT) ? LIMIT : ld_val;
            tc    <= 1'b0;
        end else if (en) begin
            count <= nxt;
            tc    <= bnd;
            ovf   <= ovf | (bnd & up_dn);
            unf   <= unf | (bnd & ~up_dn);
        end else begin
            tc    <= 1'b0;
        end
    end
`ifdef STEP_COUNTER_SNAPSHOT_EN
    // capture the pre-update count whenever a snapshot is requested
    always_ff @(posedge clk) begin
        if (rst) snap <= '0;
        else if (snap_req) snap <= count;
    end
`else
    logic unused_snap;
    assign unused_snap = snap_req;
    assign snap = '0;
`endif
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed table-driven check of step_counter in wrap and saturate modes plus a 16-bit default build
module tb_step_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, clr, ld, en, up;
        logic [7:0] step, ldv;
        logic [7:0] c0; logic t0, o0, u0;
        logic [7:0] c1; logic t1, o1, u1;
    } vec_t;

    logic rst, clr, en, up_dn, ld, snap_req;
    logic [7:0] step, ld_val;
    logic [7:0] count0, snap0, count1, snap1;
    logic tc0, ovf0, unf0, tc1, ovf1, unf1;

    logic rst2, en2;
    logic [15:0] step2, count2, snap2;
    logic tc2, ovf2, unf2;

    int n_chk = 0;
    int n_pass = 0;

    step_counter #(.WIDTH(8), .LIMIT(8'd99), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .step(step),
        .ld(ld), .ld_val(ld_val), .snap_req(snap_req),
        .count(count0), .tc(tc0), .ovf(ovf0), .unf(unf0), .snap(snap0));

    step_counter #(.WIDTH(8), .LIMIT(8'd99), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .step(step),
        .ld(ld), .ld_val(ld_val), .snap_req(snap_req),
        .count(count1), .tc(tc1), .ovf(ovf1), .unf(unf1), .snap(snap1));

    step_counter #(.WIDTH(16)) u_wide (
        .clk(clk), .rst(rst2), .clr(1'b0), .en(en2), .up_dn(1'b1), .step(step2),
        .ld(1'b0), .ld_val(16'd0), .snap_req(1'b0),
        .count(count2), .tc(tc2), .ovf(ovf2), .unf(unf2), .snap(snap2));

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    function automatic vec_t mk(input logic r, c, l, e, u, input int st, lv,
                                input int c0, t0, o0, u0, c1, t1, o1, u1);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.en = e; v.up = u;
        v.step = 8'(st); v.ldv = 8'(lv);
        v.c0 = 8'(c0); v.t0 = 1'(t0); v.o0 = 1'(o0); v.u0 = 1'(u0);
        v.c1 = 8'(c1); v.t1 = 1'(t1); v.o1 = 1'(o1); v.u1 = 1'(u1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tv[22];

    initial begin
        //            r  c  l  e  u  step ldv   wrap: c  t o u    sat: c  t o u
        tv[0]  = mk(1, 0, 1, 1, 1,  5,  40,   0, 0, 0, 0,    0, 0, 0, 0);
        tv[1]  = mk(0, 0, 1, 0, 1,  0,  97,  97, 0, 0, 0,   97, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 1, 1,  5,   0,   2, 1, 1, 0,   99, 1, 1, 0);
        tv[3]  = mk(0, 0, 0, 1, 1,  5,   0,   7, 0, 1, 0,   99, 1, 1, 0);
        tv[4]  = mk(0, 0, 0, 0, 1,  5,   0,   7, 0, 1, 0,   99, 0, 1, 0);
        tv[5]  = mk(0, 0, 0, 1, 1,  0,   0,   7, 0, 1, 0,   99, 0, 1, 0);
        tv[6]  = mk(0, 1, 0, 0, 1,  0,   0,   0, 0, 0, 0,    0, 0, 0, 0);
        tv[7]  = mk(0, 0, 1, 0, 0,  0,   3,   3, 0, 0, 0,    3, 0, 0, 0);
        tv[8]  = mk(0, 0, 0, 1, 0,  5,   0,  98, 1, 0, 1,    0, 1, 0, 1);
        tv[9]  = mk(0, 0, 0, 1, 0,  0,   0,  98, 0, 0, 1,    0, 0, 0, 1);
        tv[10] = mk(0, 0, 0, 1, 0,  1,   0,  97, 0, 0, 1,    0, 1, 0, 1);
        tv[11] = mk(0, 0, 1, 1, 1,  5, 200,  99, 0, 0, 1,   99, 0, 0, 1);
        tv[12] = mk(0, 0, 0, 1, 1,  0,   0,  99, 0, 0, 1,   99, 0, 0, 1);
        tv[13] = mk(0, 1, 1, 1, 1,  5,  50,   0, 0, 0, 0,    0, 0, 0, 0);
        tv[14] = mk(0, 0, 0, 1, 1, 99,   0,  99, 0, 0, 0,   99, 0, 0, 0);
        tv[15] = mk(0, 0, 0, 1, 0, 99,   0,   0, 0, 0, 0,    0, 0, 0, 0);
        tv[16] = mk(0, 0, 0, 1, 1, 10,   0,  10, 0, 0, 0,   10, 0, 0, 0);
        tv[17] = mk(1, 0, 0, 1, 1,  5,   0,   0, 0, 0, 0,    0, 0, 0, 0);
        tv[18] = mk(0, 0, 0, 1, 1,  5,   0,   5, 0, 0, 0,    5, 0, 0, 0);
        tv[19] = mk(0, 0, 1, 0, 1,  0,  99,  99, 0, 0, 0,   99, 0, 0, 0);
        tv[20] = mk(0, 0, 0, 1, 1,  1,   0,   0, 1, 1, 0,   99, 1, 1, 0);
        tv[21] = mk(0, 0, 0, 1, 0, 99,   0,   1, 1, 1, 1,    0, 0, 1, 0);

        rst = 1'b1; clr = 1'b0; en = 1'b0; up_dn = 1'b1; ld = 1'b0; snap_req = 1'b0;
        step = '0; ld_val = '0;
        rst2 = 1'b1; en2 = 1'b0; step2 = '0;

        for (int i = 0; i < 22; i++) begin
            rst = tv[i].rst; clr = tv[i].clr; ld = tv[i].ld; en = tv[i].en;
            up_dn = tv[i].up; step = tv[i].step; ld_val = tv[i].ldv;
            tick();
            chk("wrap count", i, count0, tv[i].c0);
            chk("wrap tc",    i, tc0,    tv[i].t0);
            chk("wrap ovf",   i, ovf0,   tv[i].o0);
            chk("wrap unf",   i, unf0,   tv[i].u0);
            chk("sat count",  i, count1, tv[i].c1);
            chk("sat tc",     i, tc1,    tv[i].t1);
            chk("sat ovf",    i, ovf1,   tv[i].o1);
            chk("sat unf",    i, unf1,   tv[i].u1);
        end

        rst = 1'b1; ld = 1'b0; clr = 1'b0; en = 1'b0;
        tick();
        chk("snap reset", 0, snap0, 0);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; step = 8'd5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("snap run count", i, count0, 5 * i);
        end
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("snap cap count", 0, count0, 25);
`ifdef STEP_COUNTER_SNAPSHOT_EN
        chk("snap cap", 0, snap0, 20);
`else
        chk("snap cap", 0, snap0, 0);
`endif
        tick();
        chk("snap hold count", 0, count0, 30);
`ifdef STEP_COUNTER_SNAPSHOT_EN
        chk("snap hold", 0, snap0, 20);
`else
        chk("snap hold", 0, snap0, 0);
`endif
        en = 1'b0;

        tick();
        chk("wide reset count", 0, count2, 0);
        chk("wide reset tc", 0, tc2, 0);
        rst2 = 1'b0; en2 = 1'b1; step2 = 16'd5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("wide count", i, count2, 5 * i);
            chk("wide tc", i, tc2, 0);
            chk("wide ovf", i, ovf2, 0);
        end
        chk("wide snap", 0, snap2, 0);
        chk("wide unf", 0, unf2, 0);
        en2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
